// File: rtl/btn_pkg.sv
// btn_pkg: shared types and defaults for the push-button conditioner.
//   rep_state_t      - per-channel hold-to-repeat FSM state
//   DEF_*            - default timing constants for a 100 MHz system clock
//   cnt_width()      - counter width able to hold 0 .. max_count-1 (at least 1 bit)
//   max_int()        - larger of two integers, for sizing the shared repeat counter
package btn_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DELAY  = 2'd1,
    ST_REPEAT = 2'd2
  } rep_state_t;

  localparam int DEF_N_BTN             = 4;
  localparam int DEF_DEBOUNCE_CYC      = 1_000_000;   // 10 ms
  localparam int DEF_REPEAT_EN         = 1;
  localparam int DEF_REPEAT_DELAY_CYC  = 50_000_000;  // 500 ms
  localparam int DEF_REPEAT_PERIOD_CYC = 10_000_000;  // 100 ms

  function automatic int cnt_width(input int max_count);
    return (max_count > 2) ? $clog2(max_count) : 1;
  endfunction

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/btn_channel.sv
// btn_channel: one button channel - two-flop synchroniser, debounce counter
// and hold-to-repeat FSM. All outputs come straight from flops.
//   clk, rst_n : system clock, synchronous active-low reset
//   btn        : raw asynchronous level (1 = pressed)
//   level      : debounced level
//   press, rel : one-cycle pulses on debounced 0->1 / 1->0
//   rpt        : one-cycle auto-repeat pulse
module btn_channel
  import btn_pkg::*;
#(
  parameter int DEBOUNCE_CYC      = DEF_DEBOUNCE_CYC,
  parameter int REPEAT_EN         = DEF_REPEAT_EN,
  parameter int REPEAT_DELAY_CYC  = DEF_REPEAT_DELAY_CYC,
  parameter int REPEAT_PERIOD_CYC = DEF_REPEAT_PERIOD_CYC
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn,
  output logic level,
  output logic press,
  output logic rel,
  output logic rpt
);

  localparam int DCNT_W = cnt_width(DEBOUNCE_CYC);
  localparam int RCNT_W = cnt_width(max_int(REPEAT_DELAY_CYC, REPEAT_PERIOD_CYC));
  localparam logic [DCNT_W-1:0] DCNT_LAST = DCNT_W'(DEBOUNCE_CYC - 1);
  localparam logic [RCNT_W-1:0] DLY_LAST  = RCNT_W'(REPEAT_DELAY_CYC - 1);
  localparam logic [RCNT_W-1:0] PER_LAST  = RCNT_W'(REPEAT_PERIOD_CYC - 1);

  logic              sync1;
  logic              sync2;
  logic [DCNT_W-1:0] dcnt;
  logic [DCNT_W-1:0] dcnt_nxt;
  logic              flip;
  logic              press_evt;
  logic              rel_evt;
  rep_state_t        state;
  rep_state_t        state_nxt;
  logic [RCNT_W-1:0] rcnt;
  logic [RCNT_W-1:0] rcnt_nxt;
  logic              rpt_evt;

  // Debounce: accept a new level only after DEBOUNCE_CYC consecutive disagreeing samples.
  always_comb begin
    dcnt_nxt = '0;
    flip     = 1'b0;
    if (sync2 != level) begin
      if (dcnt == DCNT_LAST) begin
        flip = 1'b1;
      end else begin
        dcnt_nxt = dcnt + DCNT_W'(1);
      end
    end else begin
      dcnt_nxt = '0;
    end
  end

  assign press_evt = flip & ~level;
  assign rel_evt   = flip &  level;

  // Repeat FSM next state. It reacts to the press event in the same edge that
  // registers press, so the first repeat lands exactly REPEAT_DELAY_CYC cycles
  // after the press pulse.
  always_comb begin
    state_nxt = state;
    rcnt_nxt  = rcnt;
    rpt_evt   = 1'b0;
    case (state)
      ST_IDLE: begin
        if (press_evt) begin
          state_nxt = ST_DELAY;
          rcnt_nxt  = '0;
        end else begin
          rcnt_nxt  = '0;
        end
      end
      ST_DELAY: begin
        if (rcnt == DLY_LAST) begin
          rpt_evt   = 1'b1;
          rcnt_nxt  = '0;
          state_nxt = ST_REPEAT;
        end else begin
          rcnt_nxt  = rcnt + RCNT_W'(1);
        end
      end
      ST_REPEAT: begin
        if (rcnt == PER_LAST) begin
          rpt_evt  = 1'b1;
          rcnt_nxt = '0;
        end else begin
          rcnt_nxt = rcnt + RCNT_W'(1);
        end
      end
      default: begin
        state_nxt = ST_IDLE;
        rcnt_nxt  = '0;
      end
    endcase
    // A release overrides everything, including a coincident repeat tick.
    if (rel_evt || (REPEAT_EN == 0)) begin
      state_nxt = ST_IDLE;
      rcnt_nxt  = '0;
      rpt_evt   = 1'b0;
    end else begin
      state_nxt = state_nxt;
    end
  end

  // Channel state and output registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
      dcnt  <= '0;
      level <= 1'b0;
      press <= 1'b0;
      rel   <= 1'b0;
      rpt   <= 1'b0;
      state <= ST_IDLE;
      rcnt  <= '0;
    end else begin
      sync1 <= btn;
      sync2 <= sync1;
      dcnt  <= dcnt_nxt;
      level <= level ^ flip;
      press <= press_evt;
      rel   <= rel_evt;
      rpt   <= rpt_evt;
      state <= state_nxt;
      rcnt  <= rcnt_nxt;
    end
  end

endmodule

// File: rtl/btn_conditioner.sv
// btn_conditioner: N_BTN independent push-button conditioning channels.
//   clk, rst_n : system clock, synchronous active-low reset
//   btn_i      : raw button levels (1 = pressed)
//   level_o    : debounced levels
//   press_o    : one-cycle pulse on debounced press
//   release_o  : one-cycle pulse on debounced release
//   repeat_o   : one-cycle hold-to-repeat pulse
//   event_o    : press_o | repeat_o (OR of flops, no added latency)
module btn_conditioner
  import btn_pkg::*;
#(
  parameter int N_BTN             = DEF_N_BTN,
  parameter int DEBOUNCE_CYC      = DEF_DEBOUNCE_CYC,
  parameter int REPEAT_EN         = DEF_REPEAT_EN,
  parameter int REPEAT_DELAY_CYC  = DEF_REPEAT_DELAY_CYC,
  parameter int REPEAT_PERIOD_CYC = DEF_REPEAT_PERIOD_CYC
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N_BTN-1:0] btn_i,
  output logic [N_BTN-1:0] level_o,
  output logic [N_BTN-1:0] press_o,
  output logic [N_BTN-1:0] release_o,
  output logic [N_BTN-1:0] repeat_o,
  output logic [N_BTN-1:0] event_o
);

  if (N_BTN < 1) begin : g_bad_n_btn
    $error("btn_conditioner: N_BTN must be >= 1");
  end
  if (DEBOUNCE_CYC < 2) begin : g_bad_debounce
    $error("btn_conditioner: DEBOUNCE_CYC must be >= 2");
  end
  if (REPEAT_DELAY_CYC < 2) begin : g_bad_delay
    $error("btn_conditioner: REPEAT_DELAY_CYC must be >= 2");
  end
  if (REPEAT_PERIOD_CYC < 2) begin : g_bad_period
    $error("btn_conditioner: REPEAT_PERIOD_CYC must be >= 2");
  end

  for (genvar i = 0; i < N_BTN; i++) begin : g_ch
    btn_channel #(
      .DEBOUNCE_CYC      (DEBOUNCE_CYC),
      .REPEAT_EN         (REPEAT_EN),
      .REPEAT_DELAY_CYC  (REPEAT_DELAY_CYC),
      .REPEAT_PERIOD_CYC (REPEAT_PERIOD_CYC)
    ) u_ch (
      .clk   (clk),
      .rst_n (rst_n),
      .btn   (btn_i[i]),
      .level (level_o[i]),
      .press (press_o[i]),
      .rel   (release_o[i]),
      .rpt   (repeat_o[i])
    );
  end

  assign event_o = press_o | repeat_o;

endmodule

// File: tb/tb_btn_conditioner.sv
// tb_btn_conditioner: directed bench for btn_conditioner with DEBOUNCE_CYC=4,
// REPEAT_DELAY_CYC=10, REPEAT_PERIOD_CYC=3. Two instances share the stimulus:
// dut (repeat enabled) and dut_nr (repeat disabled).
module tb_btn_conditioner;

  logic       clk;
  logic       rst_n;
  logic [3:0] btn;
  logic [3:0] level_o, press_o, release_o, repeat_o, event_o;
  logic [3:0] nr_level, nr_press, nr_release, nr_repeat, nr_event;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic       rst_n;
    logic [3:0] btn;
    logic [3:0] lvl;
    logic [3:0] prs;
    logic [3:0] rel;
    logic [3:0] rpt;
  } vec_t;

  vec_t vecs[$];

  btn_conditioner #(
    .N_BTN(4), .DEBOUNCE_CYC(4), .REPEAT_EN(1),
    .REPEAT_DELAY_CYC(10), .REPEAT_PERIOD_CYC(3)
  ) dut (
    .clk(clk), .rst_n(rst_n), .btn_i(btn),
    .level_o(level_o), .press_o(press_o), .release_o(release_o),
    .repeat_o(repeat_o), .event_o(event_o)
  );

  btn_conditioner #(
    .N_BTN(4), .DEBOUNCE_CYC(4), .REPEAT_EN(0),
    .REPEAT_DELAY_CYC(10), .REPEAT_PERIOD_CYC(3)
  ) dut_nr (
    .clk(clk), .rst_n(rst_n), .btn_i(btn),
    .level_o(nr_level), .press_o(nr_press), .release_o(nr_release),
    .repeat_o(nr_repeat), .event_o(nr_event)
  );

  always #5 clk = ~clk;

  function automatic void add_vec(input logic r, input logic [3:0] b, input logic [3:0] l,
                                  input logic [3:0] p, input logic [3:0] rl, input logic [3:0] rp);
    vec_t v;
    v.rst_n = r; v.btn = b; v.lvl = l; v.prs = p; v.rel = rl; v.rpt = rp;
    vecs.push_back(v);
  endfunction

  task automatic chk(input string name, input logic [3:0] act, input logic [3:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %b, expected %b", name, $time, act, exp);
    end
  endtask

  // Both instances must agree on level/press/release; only dut may repeat.
  task automatic check_outputs(input string tag, input logic [3:0] lvl, input logic [3:0] prs,
                               input logic [3:0] rel, input logic [3:0] rpt);
    chk({tag, " level"},      level_o,    lvl);
    chk({tag, " press"},      press_o,    prs);
    chk({tag, " release"},    release_o,  rel);
    chk({tag, " repeat"},     repeat_o,   rpt);
    chk({tag, " event"},      event_o,    prs | rpt);
    chk({tag, " nr_level"},   nr_level,   lvl);
    chk({tag, " nr_press"},   nr_press,   prs);
    chk({tag, " nr_release"}, nr_release, rel);
    chk({tag, " nr_repeat"},  nr_repeat,  4'b0000);
    chk({tag, " nr_event"},   nr_event,   prs);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [3:0] b5;
    logic [3:0] z;
    clk   = 1'b0;
    rst_n = 1'b0;
    btn   = 4'b0000;
    b5    = 4'b0101;
    z     = 4'b0000;

    // Buttons held through reset, then repeats, then a release that
    // coincides with a repeat tick (edge 25 after reset release).
    repeat (3) add_vec(1'b0, b5, z, z, z, z);
    repeat (5) add_vec(1'b1, b5, z, z, z, z);   // edges 1-5
    add_vec(1'b1, b5, b5, b5, z, z);            // edge 6: press
    repeat (9) add_vec(1'b1, b5, b5, z, z, z);  // edges 7-15
    add_vec(1'b1, b5, b5, z, z, b5);            // edge 16: first repeat
    repeat (2) add_vec(1'b1, b5, b5, z, z, z);
    add_vec(1'b1, b5, b5, z, z, b5);            // edge 19
    repeat (2) add_vec(1'b1, z, b5, z, z, z);   // edges 20-21, buttons dropped
    add_vec(1'b1, z, b5, z, z, b5);             // edge 22
    repeat (2) add_vec(1'b1, z, b5, z, z, z);
    add_vec(1'b1, z, z, z, b5, z);              // edge 25: release beats repeat
    repeat (5) add_vec(1'b1, z, z, z, z, z);    // edges 26-30: FSM idle

    for (int i = 0; i < vecs.size(); i++) begin
      rst_n = vecs[i].rst_n;
      btn   = vecs[i].btn;
      step();
      check_outputs($sformatf("vec%0d", i), vecs[i].lvl, vecs[i].prs, vecs[i].rel, vecs[i].rpt);
    end

    // Glitches of 1..3 cycles on bit 2 are discarded; 4 cycles is accepted.
    for (int len = 1; len <= 4; len++) begin
      for (int k = 1; k <= 14; k++) begin
        logic acc;
        acc = (len == 4);
        btn = (k <= len) ? 4'b0100 : 4'b0000;
        step();
        check_outputs($sformatf("glitch%0d_k%0d", len, k),
                      (acc && k >= 6 && k <= 9) ? 4'b0100 : 4'b0000,
                      (acc && k == 6)           ? 4'b0100 : 4'b0000,
                      (acc && k == 10)          ? 4'b0100 : 4'b0000,
                      4'b0000);
      end
    end

    // Bit 0 held: press at 6, repeats at 16,19,...,34; release at 37 on a tick.
    for (int k = 1; k <= 42; k++) begin
      btn = (k <= 31) ? 4'b0001 : 4'b0000;
      step();
      check_outputs($sformatf("hold0_k%0d", k),
                    (k >= 6 && k <= 36) ? 4'b0001 : 4'b0000,
                    (k == 6)            ? 4'b0001 : 4'b0000,
                    (k == 37)           ? 4'b0001 : 4'b0000,
                    (k >= 16 && k <= 34 && (k - 16) % 3 == 0) ? 4'b0001 : 4'b0000);
    end

    // Bit 1 held, one-cycle reset at edge 20 mid-repeat: fresh press 6 edges later.
    for (int k = 1; k <= 50; k++) begin
      int  j;
      logic l, p, rl, rp;
      rst_n = (k == 20) ? 1'b0 : 1'b1;
      btn   = (k <= 40) ? 4'b0010 : 4'b0000;
      step();
      if (k < 20) begin
        l  = (k >= 6);
        p  = (k == 6);
        rl = 1'b0;
        rp = (k == 16) || (k == 19);
      end else if (k == 20) begin
        l = 1'b0; p = 1'b0; rl = 1'b0; rp = 1'b0;
      end else begin
        j  = k - 20;
        l  = (j >= 6) && (k <= 45);
        p  = (j == 6);
        rl = (k == 46);
        rp = (j >= 16) && ((j - 16) % 3 == 0) && (k <= 45);
      end
      check_outputs($sformatf("rst1_k%0d", k),
                    {2'b00, l, 1'b0}, {2'b00, p, 1'b0}, {2'b00, rl, 1'b0}, {2'b00, rp, 1'b0});
    end

    // All buttons held 40 cycles: dut_nr never repeats; dut release at 46 beats tick.
    for (int k = 1; k <= 50; k++) begin
      btn = (k <= 40) ? 4'b1111 : 4'b0000;
      step();
      check_outputs($sformatf("all_k%0d", k),
                    (k >= 6 && k <= 45) ? 4'b1111 : 4'b0000,
                    (k == 6)            ? 4'b1111 : 4'b0000,
                    (k == 46)           ? 4'b1111 : 4'b0000,
                    (k >= 16 && k <= 45 && (k - 16) % 3 == 0) ? 4'b1111 : 4'b0000);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/btn_conditioner.md
# btn_conditioner

Parametrised multi-channel push-button input conditioner between the raw board buttons (`btnl_i`, `btnu_i`, `btnr_i`, `btnd_i` and future additions) and the game/control logic inside `bil265_proje_top`. Each channel is synchronised, debounced and turned into clean one-cycle press/release pulses. An optional hold-to-repeat generator emits periodic pulses while a button stays held. Channels are fully independent.

## Interface
- `N_BTN`, default 4: number of button channels (≥1).
- `DEBOUNCE_CYC`, default 1_000_000: consecutive stable cycles needed to accept a level change (≥2; 10 ms at 100 MHz).
- `REPEAT_EN`, default 1: 1 enables hold-to-repeat; 0 forces `repeat_o` to 0.
- `REPEAT_DELAY_CYC`, default 50_000_000: cycles from press pulse to first repeat pulse (≥2).
- `REPEAT_PERIOD_CYC`, default 10_000_000: cycles between subsequent repeat pulses (≥2).

Ports:
- `clk` input 1: single system clock.
- `rst_n` input 1: reset; one clock, reset is synchronous and active-low.
- `btn_i` input N_BTN: raw asynchronous button levels, 1 = pressed.
- `level_o` output N_BTN: debounced level.
- `press_o` output N_BTN: one-cycle pulse on debounced 0→1.
- `release_o` output N_BTN: one-cycle pulse on debounced 1→0.
- `repeat_o` output N_BTN: one-cycle auto-repeat pulse.
- `event_o` output N_BTN: `press_o | repeat_o`, registered-equivalent (no extra latency).

## Operation
- Synchroniser: two flops per channel (`sync1`, `sync2`), reset to 0.
- Debounce: counter `dcnt` per channel, width `$clog2(DEBOUNCE_CYC)`.
  - `sync2 == level`: `dcnt` ← 0.
  - `sync2 != level` and `dcnt < DEBOUNCE_CYC-1`: `dcnt` increments.
  - `sync2 != level` and `dcnt == DEBOUNCE_CYC-1`: `level` toggles, `dcnt` ← 0, and the matching `press_o`/`release_o` bit is 1 for that one cycle.
  - A disagreement lasting fewer than `DEBOUNCE_CYC` cycles is discarded without a pulse.
- Repeat FSM per channel: IDLE, DELAY, REPEAT, with counter `rcnt` sized to `max(REPEAT_DELAY_CYC, REPEAT_PERIOD_CYC)`.
  - IDLE → DELAY on a press pulse, `rcnt` ← 0.
  - DELAY: `rcnt` increments. At `REPEAT_DELAY_CYC-1`, pulse `repeat_o`, `rcnt` ← 0, go to REPEAT.
  - REPEAT: at `REPEAT_PERIOD_CYC-1`, pulse `repeat_o` and set `rcnt` ← 0.
  - Release pulse in any state → IDLE, `rcnt` ← 0. Release wins over a coincident repeat tick, so no pulse is emitted.
  - `REPEAT_EN=0`: FSM held in IDLE.
- Reset, at any time including mid-debounce or mid-repeat: every flop, counter and output goes to 0 and the FSM to IDLE on the next edge with `rst_n=0`. A button held through reset is re-detected as a fresh press after release of reset.
- Elaboration check: `$error` if any parameter is below its minimum.

## Timing
- Output reset values: `level_o`, `press_o`, `release_o`, `repeat_o` and `event_o` are all 0.
- Edge 1 is the first rising edge that samples a new, stable `btn_i` value. `level_o` and the press/release pulse update at edge `DEBOUNCE_CYC+2`.
- First `repeat_o` fires exactly `REPEAT_DELAY_CYC` cycles after the `press_o` cycle. Later pulses are spaced `REPEAT_PERIOD_CYC` cycles apart.
- `press_o`, `release_o` and `repeat_o` are never high for two consecutive cycles. `press_o` and `repeat_o` are never high in the same cycle.
- All outputs are driven directly from flops, except `event_o`, which is an OR of flops.

## Structure
- Package `btn_pkg`: repeat state enum (IDLE/DELAY/REPEAT) and default timing constants for 100 MHz.
- Sub-module `btn_channel`: one channel's synchroniser, debounce counter and repeat FSM. `btn_conditioner` instantiates it `N_BTN` times in a generate loop.

## Test plan
All scenarios use `N_BTN=4`, `DEBOUNCE_CYC=4`, `REPEAT_DELAY_CYC=10`, `REPEAT_PERIOD_CYC=3`.
- `btn_i=4'b0101` held through reset, then `rst_n` released: outputs stay 0 during reset. `press_o=4'b0101` for one cycle 6 edges after release, and `level_o=4'b0101` thereafter.
- Glitch pulses of 1, 2 and 3 cycles on bit 2: `level_o[2]` stays 0 and no pulses. A 4-cycle pulse → `press_o[2]` fires, followed later by `release_o[2]`.
- Hold bit 0 for 25 cycles after its press: `repeat_o[0]` pulses at press+10, +13, +16, +19, +22, +25, and `event_o[0]` matches press plus repeats.
- Release bit 0 so that its release pulse coincides with a repeat tick: `release_o[0]`=1, `repeat_o[0]`=0, FSM returns to IDLE.
- `rst_n` asserted for 1 cycle mid-repeat on bit 1 while `btn_i[1]` stays held: all outputs return to 0. A new `press_o[1]` fires 6 edges after release, then the first repeat comes 10 cycles later.
- `REPEAT_EN=0` with all buttons held for 40 cycles: `repeat_o` stays 0 throughout, and press/release behave as before.
